alu_input_seq: RTL

Operand entry sequencer sitting directly upstream of the 4-bit ALU on the board. It debounces two push-buttons and steps the user through entering operand x, operand y and the 3-bit operation from slide switches. It drives the ALU's x/y/select inputs from registers and captures the ALU's combinational result and flags into a stable result register one cycle later. The result register feeds the display path.

---
 rtl/alu_io_pkg.sv | 16 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/alu_input_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_io_pkg.sv
// Shared widths and sequencer state encoding for the ALU operand-entry path.
// The ALU and display blocks use the same width constants.
package alu_io_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 3;

  typedef enum logic [1:0] {
    S_X   = 2'b00,
    S_Y   = 2'b01,
    S_OP  = 2'b10,
    S_RES = 2'b11
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and accepted
// level, plus a registered pulse in the first cycle the level reads 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // The counter clears at the terminal count, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q1    <= btn_raw;
      sync_q2    <= sync_q1;
      rise_pulse <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        level      <= sync_q2;
        cnt        <= '0;
        rise_pulse <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_input_seq.sv
// Operand entry sequencer: steps through x, y and op entry on debounced button
// presses, drives the ALU inputs and captures its result one cycle later.
//
// state | meaning
// S_X   | waiting for next press to latch operand x from sw
// S_Y   | waiting for next press to latch operand y from sw
// S_OP  | waiting for next press to latch select from op_sw
// S_RES | result captured/being captured; next press returns to S_X
module alu_input_seq
  import alu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic [OP_W-1:0]   op_sw,
  input  logic              btn_next,
  input  logic              btn_clr,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic [OP_W-1:0]   select,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] result_flags,
  output logic [1:0]        stage,
  output logic              done
);

  logic next_level, next_rise;
  logic clr_level, clr_rise;
  logic next_go, clr_go;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_next),
    .level     (next_level),
    .rise_pulse(next_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_clr),
    .level     (clr_level),
    .rise_pulse(clr_rise)
  );

  // The pulse always coincides with the level first reading 1; gating keeps a
  // stray pulse on a released button from advancing the sequence.
  assign next_go = next_rise & next_level;
  assign clr_go  = clr_rise & clr_level;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] x_nxt, y_nxt;
  logic [OP_W-1:0]   sel_nxt;
  logic              cap_pending, cap_pending_nxt;
  logic              cap_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_X;
      x           <= '0;
      y           <= '0;
      select      <= '0;
      cap_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      select      <= sel_nxt;
      cap_pending <= cap_pending_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    x_nxt           = x;
    y_nxt           = y;
    sel_nxt         = select;
    cap_pending_nxt = 1'b0;
    cap_en          = 1'b0;
    if (clr_go) begin
      state_nxt = S_X;
      x_nxt     = '0;
      y_nxt     = '0;
      sel_nxt   = '0;
    end else begin
      cap_en = cap_pending;
      if (next_go) begin
        unique case (state)
          S_X: begin
            x_nxt     = sw;
            state_nxt = S_Y;
          end
          S_Y: begin
            y_nxt     = sw;
            state_nxt = S_OP;
          end
          S_OP: begin
            sel_nxt         = op_sw;
            state_nxt       = S_RES;
            cap_pending_nxt = 1'b1;
          end
          S_RES: state_nxt = S_X;
          default: state_nxt = S_X;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_flags <= '0;
      done         <= 1'b0;
    end else begin
      done <= cap_en;
      if (clr_go) begin
        result       <= '0;
        result_flags <= '0;
      end else if (cap_en) begin
        result       <= alu_out;
        result_flags <= alu_flags;
      end
    end
  end

  assign stage = state;

endmodule
